inst_fetch: RTL and testbench

Instruction fetch stage of the five-stage CPU. Holds the program counter and a synchronous-read instruction memory, and delivers 32-bit instruction words to the decode/execute stage through a valid/ready handshake. The delivered word is the IR consumed downstream. A 2-entry skid FIFO absorbs memory read latency and decode back-pressure. The block also supports PC redirect (branch/jump) and stops issuing at a HALT opcode.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/inst_fetch_if.sv | 19 +
 rtl/inst_fetch_fifo.sv | 48 ++++
 rtl/inst_fetch.sv | 137 +++++++++++++
 tb/tb_inst_fetch.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline stages.
//   INST_W       instruction word width
//   opcode_e     opcode encodings carried in the oper field
//   *_HI/*_LO    bit positions of the IR fields
//   is_halt()    true when a word carries the HALT opcode
package cpu_pkg;

   localparam int INST_W = 32;

   typedef enum logic [4:0] {
      OP_MOVSGPR = 5'd0,
      OP_MOV     = 5'd1,
      OP_ADD     = 5'd2,
      OP_SUB     = 5'd3,
      OP_MUL     = 5'd4,
      OP_HALT    = 5'd31
   } opcode_e;

   localparam int OPER_HI      = 31;
   localparam int OPER_LO      = 27;
   localparam int RDST_HI      = 26;
   localparam int RDST_LO      = 22;
   localparam int RSRC1_HI     = 21;
   localparam int RSRC1_LO     = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_HI     = 15;
   localparam int RSRC2_LO     = 11;
   localparam int ISRC_HI      = 15;
   localparam int ISRC_LO      = 0;

   function automatic logic is_halt(input logic [INST_W-1:0] word);
      return word[OPER_HI:OPER_LO] == OP_HALT;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: instruction hand-off from fetch to decode.
//   ir_out    instruction word (IR)
//   ir_valid  ir_out/ir_pc are valid
//   ir_ready  downstream accepts the word this cycle
//   ir_pc     PC of ir_out
// master = fetch side, slave = decode side.
interface inst_fetch_if
   import cpu_pkg::*;
#(
   parameter int PC_W = 4
);
   logic [INST_W-1:0] ir_out;
   logic              ir_valid;
   logic              ir_ready;
   logic [PC_W-1:0]   ir_pc;

   modport master (output ir_out, output ir_valid, output ir_pc, input ir_ready);
   modport slave  (input ir_out, input ir_valid, input ir_pc, output ir_ready);
endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of {pc, word} between the instruction memory
// read port and the decode handshake.
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data at the tail
//   pop         drop the head entry
//   flush       discard every entry (takes priority over push/pop)
//   count       number of stored entries (0..2)
//   head_data   head entry, meaningful when head_vld
//   head_vld    FIFO not empty
module fetch_fifo #(
   parameter int ENTRY_W = 36
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] push_data,
   input  logic               pop,
   input  logic               flush,
   output logic [1:0]         count,
   output logic [ENTRY_W-1:0] head_data,
   output logic               head_vld
);

   logic [ENTRY_W-1:0] mem [2];
   logic               wr_ptr;
   logic               rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage carries no reset; head_vld qualifies it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head_data = mem[rd_ptr];
   assign head_vld  = (count != 2'd0);

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Holds the PC and a synchronous-read
// instruction memory and hands 32-bit words to decode over a valid/ready
// interface, with a 2-entry skid FIFO, PC redirect and stop-at-HALT.
//   clk, sys_rst       clock, synchronous active-high reset
//   prog_we/addr/wdata program load port, honoured only while run=0
//   run                enables fetching
//   redirect_valid/pc  one-cycle pulse: load PC, flush, clear halted
//   ir_if (master)     ir_out / ir_valid / ir_ready / ir_pc
//   halted             a HALT word has been fetched; issue stopped
// Build option: define FETCH_PERF_EN to add fetch_cnt (handshakes) and
// stall_cnt (cycles with ir_valid & !ir_ready), both saturating.
module inst_fetch
   import cpu_pkg::*;
#(
   parameter int IMEM_DEPTH = 16,
   parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [INST_W-1:0] prog_wdata,
   input  logic              run,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   inst_fetch_if.master      ir_if,
   output logic              halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int ENTRY_W = PC_W + INST_W;

   logic [INST_W-1:0]  imem [IMEM_DEPTH];

   logic [PC_W-1:0]    pc_p0;
   logic               issue_p0;
   logic [2:0]         occ_p0;

   logic               vld_p1;
   logic [PC_W-1:0]    pc_p1;
   logic [INST_W-1:0]  word_p1;
   logic               push_p1;
   logic               halt_push_p1;

   logic [1:0]         fifo_count;
   logic [ENTRY_W-1:0] head;
   logic               head_vld;
   logic               pop;

   // ---- stage p0: issue ----
   assign pop = ir_if.ir_valid & ir_if.ir_ready;

   // Occupancy counts the handshake of this cycle as already gone, so a
   // slot freed by decode can be reserved immediately; that keeps the
   // stream at one word per cycle while still never overflowing the FIFO.
   assign occ_p0 = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};

   // halted only rises on the edge after the HALT word lands, so the landing
   // cycle itself must also block issue or the word after HALT would leak.
   assign issue_p0 = run && !halted && !redirect_valid && !halt_push_p1 &&
                     (occ_p0 < 3'd2);

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         pc_p0  <= '0;
         vld_p1 <= 1'b0;
         halted <= 1'b0;
      end else begin
         vld_p1 <= issue_p0;
         if (redirect_valid) begin
            pc_p0  <= redirect_pc;
            halted <= 1'b0;
         end else begin
            if (issue_p0)     pc_p0  <= pc_p0 + PC_W'(1);
            if (halt_push_p1) halted <= 1'b1;
         end
      end
   end

   // Memory write and synchronous read; the read port is only used while
   // run=1, when writes are locked out.
   always_ff @(posedge clk) begin
      if (prog_we && !run) imem[prog_addr] <= prog_wdata;
      if (issue_p0) begin
         word_p1 <= imem[pc_p0];
         pc_p1   <= pc_p0;
      end
   end

   // ---- stage p1: read return into the FIFO ----
   // A redirect in the return cycle discards the word in flight.
   assign push_p1      = vld_p1 && !redirect_valid;
   assign halt_push_p1 = push_p1 && is_halt(word_p1);

   fetch_fifo #(
      .ENTRY_W (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (sys_rst),
      .push      (push_p1),
      .push_data ({pc_p1, word_p1}),
      .pop       (pop),
      .flush     (redirect_valid),
      .count     (fifo_count),
      .head_data (head),
      .head_vld  (head_vld)
   );

   // ---- output: FIFO head ----
   // Zero the bus when empty so it reads 0 out of reset.
   assign ir_if.ir_valid = head_vld;
   assign ir_if.ir_out   = head_vld ? head[INST_W-1:0] : '0;
   assign ir_if.ir_pc    = head_vld ? head[ENTRY_W-1:INST_W] : '0;

`ifdef FETCH_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop) fetch_cnt <= sat_inc(fetch_cnt);
         if (ir_if.ir_valid && !ir_if.ir_ready) stall_cnt <= sat_inc(stall_cnt);
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

   localparam int IMEM_DEPTH = 16;
   localparam int PC_W       = 4;
   localparam int EW         = PC_W + 32;
   typedef logic [EW-1:0] ent_t;

   logic              clk;
   logic              sys_rst;
   logic              prog_we;
   logic [PC_W-1:0]   prog_addr;
   logic [31:0]       prog_wdata;
   logic              run;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              halted;
`ifdef FETCH_PERF_EN
   logic [31:0]       fetch_cnt;
   logic [31:0]       stall_cnt;
`endif

   inst_fetch_if #(.PC_W(PC_W)) ir_if ();

   inst_fetch #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) dut (
      .clk            (clk),
      .sys_rst        (sys_rst),
      .prog_we        (prog_we),
      .prog_addr      (prog_addr),
      .prog_wdata     (prog_wdata),
      .run            (run),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ir_if          (ir_if),
      .halted         (halted)
`ifdef FETCH_PERF_EN
      ,
      .fetch_cnt      (fetch_cnt),
      .stall_cnt      (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ent_t exp_q [$];
   logic [31:0] model_mem [IMEM_DEPTH];

   task automatic check(input bit ok, input string name,
                        input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the words decode should see starting at 'start' run
   // sequentially (wrapping) up to and including the first HALT.
   task automatic push_stream(input int start);
      int a;
      a = start;
      for (int n = 0; n < IMEM_DEPTH; n++) begin
         exp_q.push_back({PC_W'(a), model_mem[a]});
         if (model_mem[a][31:27] == 5'b11111) break;
         a = (a + 1) % IMEM_DEPTH;
      end
   endtask

   task automatic write_mem(input int a, input logic [31:0] d);
      prog_we    = 1'b1;
      prog_addr  = PC_W'(a);
      prog_wdata = d;
      model_mem[a] = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      exp_q.delete();
      sys_rst = 1'b1;
      run = 1'b0;
      prog_we = 1'b0;
      redirect_valid = 1'b0;
      ir_if.ir_ready = 1'b0;
      tick();
      sys_rst = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc;
      cyc = 0;
      ir_if.ir_ready = 1'b1;
      run = 1'b1;
      prog_we = 1'b0;
      redirect_valid = 1'b0;
      while ((exp_q.size() != 0 || halted !== 1'b1) && cyc < 200) begin
         tick();
         cyc++;
      end
      check(cyc < 200, {name, "_drain_timeout"}, cyc, 200);
      repeat (4) tick();
      check(halted === 1'b1, {name, "_halted"}, halted, 1);
   endtask

   // Monitor: pops the scoreboard on every handshake, checks hold-under-stall.
   bit               prev_stall = 1'b0;
   logic [31:0]      prev_out;
   logic [PC_W-1:0]  prev_pc;

   always @(negedge clk) begin : monitor
      ent_t e;
      if (prev_stall) begin
         check(ir_if.ir_valid === 1'b1, "hold_valid", ir_if.ir_valid, 1);
         check(ir_if.ir_out === prev_out && ir_if.ir_pc === prev_pc, "hold_word",
               {ir_if.ir_pc, ir_if.ir_out}, {prev_pc, prev_out});
      end
      if (ir_if.ir_valid === 1'b1 && ir_if.ir_out[31:27] === 5'b11111)
         check(halted === 1'b1, "halted_with_halt_word", halted, 1);
      if (ir_if.ir_valid === 1'b1 && ir_if.ir_ready === 1'b1) begin
         check(exp_q.size() != 0, "extra_word", {ir_if.ir_pc, ir_if.ir_out}, 0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(ir_if.ir_pc === e[EW-1:32], "ir_pc", ir_if.ir_pc, e[EW-1:32]);
            check(ir_if.ir_out === e[31:0], "ir_out", ir_if.ir_out, e[31:0]);
         end
      end
      prev_stall = (ir_if.ir_valid === 1'b1) && (ir_if.ir_ready === 1'b0) &&
                   (redirect_valid === 1'b0) && (sys_rst === 1'b0);
      prev_out = ir_if.ir_out;
      prev_pc  = ir_if.ir_pc;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sys_rst = 1'b1;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_wdata = '0;
      run = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      ir_if.ir_ready = 1'b0;
      for (int i = 0; i < IMEM_DEPTH; i++) model_mem[i] = 32'h0;

      // Reset state
      do_reset();
      check(ir_if.ir_valid === 1'b0, "rst_ir_valid", ir_if.ir_valid, 0);
      check(ir_if.ir_out === 32'h0, "rst_ir_out", ir_if.ir_out, 0);
      check(ir_if.ir_pc === '0, "rst_ir_pc", ir_if.ir_pc, 0);
      check(halted === 1'b0, "rst_halted", halted, 0);

      // Basic program, latency and steady-state streaming
      for (int i = 0; i < IMEM_DEPTH; i++) write_mem(i, 32'h0);
      write_mem(0, 32'h1004_0004);
      write_mem(1, 32'h1008_2800);
      write_mem(2, 32'h0901_0037);
      write_mem(3, 32'hF800_0000);
      ir_if.ir_ready = 1'b1;
      run = 1'b1;
      push_stream(0);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b0, "lat_cycle0", ir_if.ir_valid, 0);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b0, "lat_cycle1", ir_if.ir_valid, 0);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b1, "lat_cycle2", ir_if.ir_valid, 1);
      for (int c = 3; c <= 5; c++) begin
         @(negedge clk);
         check(ir_if.ir_valid === 1'b1, "no_bubble", c, 1);
      end
      wait_done("basic");

      // Back-pressure: ready low for cycles 0..7 (stalls in 2..7)
      do_reset();
      run = 1'b1;
      push_stream(0);
      repeat (8) tick();
      ir_if.ir_ready = 1'b1;
      wait_done("stall");
`ifdef FETCH_PERF_EN
      check(fetch_cnt === 32'd4, "fetch_cnt", fetch_cnt, 4);
      check(stall_cnt === 32'd6, "stall_cnt", stall_cnt, 6);
`endif

      // Redirect to pc 2 in the cycle word 0 is consumed
      do_reset();
      ir_if.ir_ready = 1'b1;
      run = 1'b1;
      push_stream(0);
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc = 4'd2;
      tick();
      redirect_valid = 1'b0;
      exp_q.delete();
      push_stream(2);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b0, "redirect_bubble", ir_if.ir_valid, 0);
      wait_done("redirect");

      // PC wrap through 15 -> 0, and a load attempt while running
      do_reset();
      write_mem(15, 32'h18C4_0000);
      write_mem(0, 32'h0840_0007);
      write_mem(1, 32'h2088_2000);
      write_mem(2, 32'hF800_0000);
      ir_if.ir_ready = 1'b1;
      run = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 4'd15;
      push_stream(15);
      tick();
      redirect_valid = 1'b0;
      prog_we = 1'b1;
      prog_addr = 4'd1;
      prog_wdata = 32'h0BAD_F00D;
      tick();
      prog_we = 1'b0;
      wait_done("wrap");

      // Reset while two words are buffered
      do_reset();
      run = 1'b1;
      push_stream(0);
      repeat (4) tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      exp_q.delete();
      push_stream(0);
      check(ir_if.ir_valid === 1'b0, "midrst_ir_valid", ir_if.ir_valid, 0);
      check(halted === 1'b0, "midrst_halted", halted, 0);
      check(ir_if.ir_pc === '0, "midrst_ir_pc", ir_if.ir_pc, 0);
      ir_if.ir_ready = 1'b1;
      @(negedge clk);
      check(ir_if.ir_valid === 1'b0, "refetch_cycle0", ir_if.ir_valid, 0);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b0, "refetch_cycle1", ir_if.ir_valid, 0);
      @(negedge clk);
      check(ir_if.ir_valid === 1'b1, "refetch_cycle2", ir_if.ir_valid, 1);
      wait_done("midrst");

      // Randomized programs, back-pressure, run toggling, redirects
      for (int it = 0; it < 20; it++) begin
         int              hpos;
         int              rcyc;
         logic [31:0]     w;
         bit              do_redir;
         bit              redir_pend;
         logic [PC_W-1:0] rpc;
         do_reset();
         hpos = int'($urandom_range(0, IMEM_DEPTH - 1));
         for (int a = 0; a < IMEM_DEPTH; a++) begin
            w = $urandom;
            if (a == hpos) w[31:27] = 5'b11111;
            else if (w[31:27] == 5'b11111) w[31] = 1'b0;
            write_mem(a, w);
         end
         do_redir = ($urandom_range(0, 1) == 1);
         rcyc = int'($urandom_range(0, 15));
         rpc = PC_W'($urandom_range(0, IMEM_DEPTH - 1));
         redir_pend = 1'b0;
         push_stream(0);
         for (int cyc = 0; cyc < 30; cyc++) begin
            run = ($urandom_range(0, 4) != 0);
            ir_if.ir_ready = ($urandom_range(0, 9) < 7);
            prog_we = 1'b0;
            redirect_valid = 1'b0;
            if (redir_pend) begin
               exp_q.delete();
               push_stream(int'(rpc));
               redir_pend = 1'b0;
            end
            if (do_redir && cyc == rcyc) begin
               redirect_valid = 1'b1;
               redirect_pc = rpc;
               redir_pend = 1'b1;
            end else if (run && $urandom_range(0, 3) == 0) begin
               prog_we = 1'b1;
               prog_addr = PC_W'($urandom_range(0, IMEM_DEPTH - 1));
               prog_wdata = $urandom;
            end
            tick();
         end
         wait_done("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
